buf_replay_reader: RTL

- Read-side sequencer placed directly downstream of the obli data buffer.
- After a start pulse, it replays the buffer's N stored words P times in order by driving the buffer's re port.
- It realigns the buffer's 1-cycle read data and presents it as a valid/ready stream to the consuming PE array.
- A 2-entry skid store absorbs the BRAM latency, so full throughput (1 word/cycle) holds under backpressure.

---
 rtl/buf_replay_reader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/buf_replay_reader.sv
// buf_replay_reader: replays a buffer's N stored words P times as a valid/ready stream.
// Optional feature macro BUF_REACHEND_CHECK_EN adds a sticky err flag checked against buf_reachend.
module buf_replay_reader #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned MAX_nDATA  = 1024,
   parameter int unsigned MAX_nPASS  = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        start,
   input  logic [$clog2(MAX_nDATA):0]  n_data,
   input  logic [$clog2(MAX_nPASS):0]  n_pass,
   input  logic                        buf_we,
   input  logic [DATA_WIDTH-1:0]       buf_data,
   input  logic                        buf_reachend,
   output logic                        buf_re,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_first,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done
`ifdef BUF_REACHEND_CHECK_EN
   ,
   output logic                        err
`endif
);

   localparam int unsigned ND_W = $clog2(MAX_nDATA) + 1;
   localparam int unsigned NP_W = $clog2(MAX_nPASS) + 1;
   localparam int unsigned EW   = DATA_WIDTH + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [ND_W-1:0] nd_q, nd_d, elem_q, elem_d;
   logic [NP_W-1:0] np_q, np_d, pass_q, pass_d;
   logic [1:0]      occ_q, occ_d;
   logic            infl_q, infl_d;
   logic [1:0]      tag_q, tag_d;
   logic [EW-1:0]   ent0_q, ent0_d, ent1_q, ent1_d;
   logic            done_q, done_d;

   logic            pop_c, re_c, last_elem_c, final_rd_c;
   logic [2:0]      fill_c;
   logic [EW-1:0]   new_c;

   // Read issue: never let skid entries plus the in-flight word exceed two.
   assign pop_c       = (occ_q != 2'd0) && out_ready;
   assign fill_c      = 3'(occ_q) + 3'(infl_q) - 3'(pop_c);
   assign re_c        = (state_q == S_RUN) && !buf_we && (fill_c < 3'd2);
   assign last_elem_c = (elem_q == nd_q - ND_W'(1));
   assign final_rd_c  = last_elem_c && (pass_q == np_q - NP_W'(1));
   assign new_c       = {buf_data, tag_q};

   always_comb begin
      state_d = state_q;
      nd_d    = nd_q;
      np_d    = np_q;
      elem_d  = elem_q;
      pass_d  = pass_q;
      occ_d   = occ_q;
      infl_d  = re_c;
      tag_d   = tag_q;
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               nd_d    = n_data;
               np_d    = n_pass;
               elem_d  = '0;
               pass_d  = '0;
               state_d = ((n_data == '0) || (n_pass == '0)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (re_c) begin
               if (last_elem_c) begin
                  elem_d = '0;
                  pass_d = pass_q + NP_W'(1);
               end else begin
                  elem_d = elem_q + ND_W'(1);
               end
               if (final_rd_c) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((occ_q == 2'd0) && !infl_q && !pop_c) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Tags travel with the read so they line up with buf_data next cycle.
      if (re_c) tag_d = {(elem_q == '0), final_rd_c};

      case ({infl_q, pop_c})
         2'b10: begin
            if (occ_q == 2'd0) ent0_d = new_c;
            else               ent1_d = new_c;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               ent0_d = new_c;
            end else begin
               ent0_d = ent1_q;
               ent1_d = new_c;
            end
         end
         default: ;
      endcase

      if (clear) begin
         state_d = S_IDLE;
         elem_d  = '0;
         pass_d  = '0;
         occ_d   = 2'd0;
         infl_d  = 1'b0;
         tag_d   = 2'b00;
         ent0_d  = '0;
         ent1_d  = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         nd_q    <= '0;
         np_q    <= '0;
         elem_q  <= '0;
         pass_q  <= '0;
         occ_q   <= 2'd0;
         infl_q  <= 1'b0;
         tag_q   <= 2'b00;
         ent0_q  <= '0;
         ent1_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         nd_q    <= nd_d;
         np_q    <= np_d;
         elem_q  <= elem_d;
         pass_q  <= pass_d;
         occ_q   <= occ_d;
         infl_q  <= infl_d;
         tag_q   <= tag_d;
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         done_q  <= done_d;
      end
   end

   assign buf_re    = re_c;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = ent0_q[EW-1:2];
   assign out_first = ent0_q[1];
   assign out_last  = ent0_q[0];
   assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done      = done_q;

`ifdef BUF_REACHEND_CHECK_EN
   logic last_rd_q, last_rd_d, err_q, err_d;

   // The buffer's end flag arrives with the data, one cycle after the last-element read.
   always_comb begin
      last_rd_d = re_c && last_elem_c;
      err_d     = err_q | (infl_q && (last_rd_q != buf_reachend));
      if (clear) begin
         last_rd_d = 1'b0;
         err_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         last_rd_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         last_rd_q <= last_rd_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_reachend;
   assign unused_reachend = buf_reachend;
`endif

endmodule
